// File: rtl/qsn_pkg.sv
// -----------------------------------------------------------------------------
// qsn_pkg
//   Shared definitions for the pipelined quasi-cyclic shift network
//   (shared_qsn_pipe) used to route LDPC messages between memory and the
//   CNU/VNU lanes.
//
//   Contents:
//     - default geometry (lanes, bits per message, number of sources)
//     - rot_amt()       : rotation applied by level k of the log-shifter
//     - lvl_per_stage() : how many shifter levels sit in each register stage
//     - qsn_in_idx()    : bit index into the flattened multi-source input bus
//     - qsn_out_idx()   : bit index into a flattened single-source bus
// -----------------------------------------------------------------------------
package qsn_pkg;

  localparam int QSN_DEF_P     = 85;  // lanes (check-node parallelism)
  localparam int QSN_DEF_QUAN  = 4;   // bits per message
  localparam int QSN_DEF_NSRC  = 3;   // number of input channels

  // Level k rotates by 2^k reduced modulo the lane count. Because the shift
  // factor is always < p, the sum of the enabled level amounts is congruent to
  // the shift factor modulo p, so the cascade realises the exact rotation.
  function automatic int rot_amt(input int k, input int p);
    int r = 1 % p;
    for (int j = 0; j < k; j++) begin
      r = (r * 2) % p;
    end
    return r;
  endfunction

  // Levels grouped in front of each register stage after the first one.
  // With a single stage there are no such groups and every level is
  // combinational behind stage 1.
  function automatic int lvl_per_stage(input int shift_w, input int pipe_stages);
    if (pipe_stages <= 1) begin
      return 0;
    end
    return (shift_w + pipe_stages - 2) / (pipe_stages - 1);
  endfunction

  // Channel c, bit-plane b, lane i of the flattened input bus.
  function automatic int qsn_in_idx(input int c, input int b, input int i,
                                    input int q, input int p);
    return (c * q + b) * p + i;
  endfunction

  // Bit-plane b, lane i of a flattened single-source bus.
  function automatic int qsn_out_idx(input int b, input int i, input int p);
    return b * p + i;
  endfunction

endpackage

// File: rtl/qsn_rot_level.sv
// -----------------------------------------------------------------------------
// qsn_rot_level
//   One level of the logarithmic cyclic shifter. When en is set, every
//   bit-plane is rotated so that output lane i takes input lane (i+AMT) mod P;
//   otherwise the data passes through unchanged. Purely combinational.
//
//   Ports:
//     en    in   1      apply this level's rotation
//     din   in   Q*P    plane b, lane i at bit b*P+i
//     dout  out  Q*P    same layout as din
// -----------------------------------------------------------------------------
module qsn_rot_level
  import qsn_pkg::*;
#(
  parameter int CHECK_PARALLELISM = QSN_DEF_P,
  parameter int QUAN_SIZE         = QSN_DEF_QUAN,
  parameter int AMT               = 1
) (
  input  logic                                   en,
  input  logic [QUAN_SIZE*CHECK_PARALLELISM-1:0] din,
  output logic [QUAN_SIZE*CHECK_PARALLELISM-1:0] dout
);

  localparam int P = CHECK_PARALLELISM;

  always_comb begin
    dout = din;
    if (en) begin
      for (int b = 0; b < QUAN_SIZE; b++) begin
        for (int i = 0; i < P; i++) begin
          dout[qsn_out_idx(b, i, P)] = din[qsn_out_idx(b, (i + AMT) % P, P)];
        end
      end
    end
  end

endmodule

// File: rtl/shared_qsn_pipe.sv
// -----------------------------------------------------------------------------
// shared_qsn_pipe
//   Pipelined, multi-source cyclic shift network for layered LDPC message
//   routing. One of NUM_SRC input channels is selected (lowest set bit of
//   in_src wins), every bit-plane is rotated so that output lane i carries
//   selected lane (i+s) mod P, and the result leaves PIPE_STAGES cycles later
//   under a valid/ready handshake. A tag travels alongside each beat.
//
//   Ports:
//     sys_clk          in   1              clock
//     rst              in   1              synchronous active-high reset
//     flush            in   1              invalidate every in-flight beat
//     in_valid         in   1              input beat valid
//     in_ready         out  1              beat accepted when in_valid&in_ready
//     sw_in            in   NUM_SRC*Q*P    channel c, plane b, lane i at
//                                          bit (c*Q+b)*P+i
//     in_src           in   NUM_SRC        one-hot channel select
//     in_shift_factor  in   SHIFT_W        rotation amount s
//     in_bypass        in   1              identity routing, s ignored
//     in_tag           in   TAG_W          opaque side-band tag
//     out_valid        out  1              output beat valid
//     out_ready        in   1              downstream accept
//     sw_out           out  Q*P            plane b, lane i at bit b*P+i
//     out_tag          out  TAG_W          tag aligned with sw_out
//     shift_err        out  1              sticky: s >= P seen on a
//                                          non-bypass accepted beat
//
//   Structure: stage 1 registers the selected channel with its resolved
//   shift. The SHIFT_W shifter levels are then split into consecutive groups,
//   one group in front of each later register stage. Levels that do not fit
//   in front of a register (only the PIPE_STAGES=1 case) drive sw_out
//   combinationally from the last stage.
// -----------------------------------------------------------------------------
module shared_qsn_pipe
  import qsn_pkg::*;
#(
  parameter int CHECK_PARALLELISM = QSN_DEF_P,
  parameter int QUAN_SIZE         = QSN_DEF_QUAN,
  parameter int NUM_SRC           = QSN_DEF_NSRC,
  parameter int PIPE_STAGES       = 2,
  parameter int TAG_W             = 4,
  parameter int SHIFT_W           = $clog2(CHECK_PARALLELISM)
) (
  input  logic                                           sys_clk,
  input  logic                                           rst,
  input  logic                                           flush,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [NUM_SRC*QUAN_SIZE*CHECK_PARALLELISM-1:0] sw_in,
  input  logic [NUM_SRC-1:0]                             in_src,
  input  logic [SHIFT_W-1:0]                             in_shift_factor,
  input  logic                                           in_bypass,
  input  logic [TAG_W-1:0]                               in_tag,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [QUAN_SIZE*CHECK_PARALLELISM-1:0]         sw_out,
  output logic [TAG_W-1:0]                               out_tag,
  output logic                                           shift_err
);

  localparam int P   = CHECK_PARALLELISM;
  localparam int QP  = QUAN_SIZE * P;
  localparam int N   = PIPE_STAGES;
  localparam int LPS = lvl_per_stage(SHIFT_W, PIPE_STAGES);

  // P always fits in SHIFT_W+1 bits, so this compare also works when P is a
  // power of two (every s is then legal).
  localparam logic [SHIFT_W:0] P_EXT = (SHIFT_W + 1)'(CHECK_PARALLELISM);

  // Register stage whose output feeds shifter level k.
  function automatic int stage_of(input int k);
    return (PIPE_STAGES == 1) ? 1 : (k / ((LPS > 0) ? LPS : 1)) + 1;
  endfunction

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [SHIFT_W-1:0] shift;  // residual shift; bit k drives level k
    logic [QP-1:0]      data;
  } stage_t;

  stage_t st_q  [1:N];
  stage_t st_d  [1:N];
  stage_t st_in [1:N];  // value each stage loads when the pipe advances

  logic          shift_err_q;
  logic          shift_err_d;
  logic          advance;
  logic          shift_oob;
  logic [QP-1:0] sel_data;
  logic [SHIFT_W-1:0] res_shift;

  logic [QP-1:0] lvl_in  [0:SHIFT_W-1];
  logic [QP-1:0] lvl_out [0:SHIFT_W-1];

  // ---------------------------------------------------------------------------
  // Handshake: the whole pipe moves together or holds together.
  // ---------------------------------------------------------------------------
  assign advance   = out_ready | ~st_q[N].valid;
  assign in_ready  = advance;
  assign out_valid = st_q[N].valid;
  assign out_tag   = st_q[N].tag;
  assign shift_err = shift_err_q;

  // ---------------------------------------------------------------------------
  // Source select. Channels are scanned from highest to lowest so the lowest
  // set bit of in_src is the last write and therefore wins. No bit set leaves
  // the all-zero default.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_data = '0;
    for (int c = NUM_SRC - 1; c >= 0; c--) begin
      if (in_src[c]) begin
        for (int b = 0; b < QUAN_SIZE; b++) begin
          for (int i = 0; i < P; i++) begin
            sel_data[qsn_out_idx(b, i, P)] = sw_in[qsn_in_idx(c, b, i, QUAN_SIZE, P)];
          end
        end
      end
    end
  end

  // An out-of-range shift is routed as identity; bypass forces identity too.
  assign shift_oob = ({1'b0, in_shift_factor} >= P_EXT);
  assign res_shift = (in_bypass || shift_oob) ? '0 : in_shift_factor;

  assign st_in[1] = '{valid: in_valid, tag: in_tag, shift: res_shift, data: sel_data};

  // ---------------------------------------------------------------------------
  // Shifter levels. The first level of each group starts from the register
  // that feeds the group; later levels chain from the previous level.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < SHIFT_W; k++) begin : g_lvl
    localparam int STG   = stage_of(k);
    localparam bit FIRST = (k == 0) || (stage_of(k - 1) != STG);

    if (FIRST) begin : g_head
      assign lvl_in[k] = st_q[STG].data;
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end

    qsn_rot_level #(
      .CHECK_PARALLELISM (P),
      .QUAN_SIZE         (QUAN_SIZE),
      .AMT               (rot_amt(k, P))
    ) u_lvl (
      .en   (st_q[STG].shift[k]),
      .din  (lvl_in[k]),
      .dout (lvl_out[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Stages 2..N capture the output of their level group. A group can be empty
  // when there are more stages than needed; that stage just retimes.
  // ---------------------------------------------------------------------------
  for (genvar j = 2; j <= N; j++) begin : g_stg
    localparam int LO = (j - 2) * LPS;
    localparam int HI = ((j - 1) * LPS < SHIFT_W) ? (j - 1) * LPS : SHIFT_W;
    logic [QP-1:0] grp_data;

    if (LO < SHIFT_W) begin : g_grp
      assign grp_data = lvl_out[HI-1];
    end else begin : g_pass
      assign grp_data = st_q[j-1].data;
    end

    assign st_in[j] = '{valid: st_q[j-1].valid, tag: st_q[j-1].tag,
                        shift: st_q[j-1].shift, data: grp_data};
  end

  // Levels fed by the last register are combinational into sw_out.
  if (stage_of(SHIFT_W - 1) == N) begin : g_out_comb
    assign sw_out = lvl_out[SHIFT_W-1];
  end else begin : g_out_reg
    assign sw_out = st_q[N].data;
  end

  // ---------------------------------------------------------------------------
  // Next state. Flush only clears the valids; data is don't-care and an
  // acceptance in the flush cycle is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    st_d = st_q;
    if (flush) begin
      for (int j = 1; j <= N; j++) begin
        st_d[j].valid = 1'b0;
      end
    end else if (advance) begin
      st_d = st_in;
    end
  end

  assign shift_err_d = shift_err_q |
                       (in_valid & in_ready & ~in_bypass & shift_oob);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      // NOTE: all stage registers, data included, are reset so sw_out and
      // out_tag read zero after reset rather than stale contents.
      for (int j = 1; j <= N; j++) begin
        st_q[j] <= '0;
      end
      shift_err_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      shift_err_q <= shift_err_d;
    end
  end

endmodule
